// File: rtl/data_mem_responder.sv
// Data-memory bus responder: internal RAM below IO_BASE, GPIO and a prescaled
// down-counting timer with sticky expiry flag in the I/O window above it.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int IO_BASE    = 'hF0,
    parameter int PRESCALE   = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic [DATA_WIDTH-1:0] mem_data_rd,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic                  timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] L_PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [ADDR_WIDTH-1:0] L_A_GPIO_OUT = ADDR_WIDTH'(IO_BASE);
    localparam logic [ADDR_WIDTH-1:0] L_A_GPIO_IN  = ADDR_WIDTH'(IO_BASE + 1);
    localparam logic [ADDR_WIDTH-1:0] L_A_CNT      = ADDR_WIDTH'(IO_BASE + 2);
    localparam logic [ADDR_WIDTH-1:0] L_A_LOAD     = ADDR_WIDTH'(IO_BASE + 3);
    localparam logic [ADDR_WIDTH-1:0] L_A_CTRL     = ADDR_WIDTH'(IO_BASE + 4);

    logic [DATA_WIDTH-1:0] r_ram [IO_BASE];

    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_gpio_out;
    logic [DATA_WIDTH-1:0] r_sync1;
    logic [DATA_WIDTH-1:0] r_sync2;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_load;
    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic                  r_expired;
    logic [PW-1:0]         r_pre;
    logic                  r_irq;

    logic                  w_is_ram;
    logic                  w_wr_gpio;
    logic                  w_wr_load;
    logic                  w_wr_ctrl;
    logic                  w_tick;
    logic                  w_expire;
    logic [DATA_WIDTH-1:0] w_ctrl;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] w_cnt_nxt;
    logic                  w_en_nxt;
    logic                  w_auto_nxt;
    logic                  w_irq_en_nxt;
    logic                  w_exp_nxt;
    logic [PW-1:0]         w_pre_nxt;

    assign mem_data_rd = r_rd_data;
    assign gpio_out    = r_gpio_out;
    assign timer_irq   = r_irq;

    always_comb begin
        w_is_ram  = (mem_addr < L_A_GPIO_OUT);
        w_wr_gpio = mem_wr_en && (mem_addr == L_A_GPIO_OUT);
        w_wr_load = mem_wr_en && (mem_addr == L_A_LOAD);
        w_wr_ctrl = mem_wr_en && (mem_addr == L_A_CTRL);
        // a LOAD write in a tick cycle swallows that tick
        w_tick    = r_en && (r_pre == L_PRE_MAX) && !w_wr_load;
        w_expire  = w_tick && (r_cnt <= DATA_WIDTH'(1));

        w_ctrl    = '0;
        w_ctrl[0] = r_en;
        w_ctrl[1] = r_auto;
        w_ctrl[6] = r_irq_en;
        w_ctrl[7] = r_expired;
    end

    always_comb begin
        w_rd_data = '0;
        if (w_is_ram) begin
            w_rd_data = r_ram[mem_addr];
        end else begin
            case (mem_addr)
                L_A_GPIO_OUT: w_rd_data = r_gpio_out;
                L_A_GPIO_IN:  w_rd_data = r_sync2;
                L_A_CNT:      w_rd_data = r_cnt;
                L_A_LOAD:     w_rd_data = r_load;
                L_A_CTRL:     w_rd_data = w_ctrl;
                default:      w_rd_data = '0;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_en_nxt     = r_en;
        w_auto_nxt   = r_auto;
        w_irq_en_nxt = r_irq_en;
        w_exp_nxt    = r_expired;
        w_pre_nxt    = r_pre;

        if (!r_en || w_wr_load || w_tick) begin
            w_pre_nxt = '0;
        end else begin
            w_pre_nxt = r_pre + PW'(1);
        end

        if (w_wr_load) begin
            w_cnt_nxt = mem_data_wr;
        end else if (w_tick) begin
            if (!w_expire) begin
                w_cnt_nxt = r_cnt - DATA_WIDTH'(1);
            end else if (r_auto) begin
                w_cnt_nxt = r_load;
            end else begin
                w_cnt_nxt = '0;
                w_en_nxt  = 1'b0;
            end
        end

        // CTRL write applied after the timer update so a written EN overrides auto-clear
        if (w_wr_ctrl) begin
            w_en_nxt     = mem_data_wr[0];
            w_auto_nxt   = mem_data_wr[1];
            w_irq_en_nxt = mem_data_wr[6];
            if (mem_data_wr[7]) begin
                w_exp_nxt = 1'b0;
            end
        end

        if (w_expire) begin
            w_exp_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en && w_is_ram) begin
            r_ram[mem_addr] <= mem_data_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_rd_data  <= '0;
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cnt      <= '0;
            r_load     <= '0;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_expired  <= 1'b0;
            r_pre      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_data  <= w_rd_data;
            r_sync1    <= gpio_in;
            r_sync2    <= r_sync1;
            if (w_wr_gpio) begin
                r_gpio_out <= mem_data_wr;
            end
            if (w_wr_load) begin
                r_load <= mem_data_wr;
            end
            r_cnt      <= w_cnt_nxt;
            r_en       <= w_en_nxt;
            r_auto     <= w_auto_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_expired  <= w_exp_nxt;
            r_pre      <= w_pre_nxt;
            r_irq      <= r_expired & r_irq_en;
        end
    end

endmodule
